// File: rtl/pf_issue_queue.sv
// Prefetch issue queue: block-aligns up to three candidates per cycle, drops duplicates,
// and issues survivors in order over valid/ready. Optional recent filter: PF_RECENT_FILTER_EN.
module pf_issue_queue #(
  parameter int QUEUE_DEPTH     = 8,
  parameter int RECENT_COUNT    = 16,
  parameter int ADDR_SIZE       = 64,
  parameter int LOG2_BLOCK_SIZE = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_SIZE-1:0]           pref_addr1_i,
  input  logic                           pref_valid1_i,
  input  logic [ADDR_SIZE-1:0]           pref_addr2_i,
  input  logic                           pref_valid2_i,
  input  logic [ADDR_SIZE-1:0]           pref_addr3_i,
  input  logic                           pref_valid3_i,
  output logic [ADDR_SIZE-1:0]           req_addr_o,
  output logic                           req_valid_o,
  input  logic                           req_ready_i,
  output logic [$clog2(QUEUE_DEPTH):0]   count_o,
  output logic [15:0]                    drop_count_o
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [ADDR_SIZE-1:0] BLOCK_MASK =
    {{(ADDR_SIZE-LOG2_BLOCK_SIZE){1'b1}}, {LOG2_BLOCK_SIZE{1'b0}}};

  logic [ADDR_SIZE-1:0] r_mem [QUEUE_DEPTH];
  logic [PW-1:0]        r_rdPtr;
  logic [PW-1:0]        r_wrPtr;
  logic [CW-1:0]        r_count;
  logic [15:0]          r_drop;

  logic [ADDR_SIZE-1:0] w_addr [3];
  logic [2:0]           w_valid;
  logic [2:0]           w_accept;
  logic [PW-1:0]        w_wrIdx [3];
  logic [1:0]           w_numAcc;
  logic [1:0]           w_numDrop;
  logic                 w_notEmpty;
  logic                 w_deq;
  logic [CW-1:0]        w_space;
  logic [QUEUE_DEPTH-1:0] w_occ;
  logic [16:0]          w_dropSum;

`ifdef PF_RECENT_FILTER_EN
  localparam int RPW = (RECENT_COUNT > 1) ? $clog2(RECENT_COUNT) : 1;
  logic [ADDR_SIZE-1:0]    r_recent [RECENT_COUNT];
  logic [RECENT_COUNT-1:0] r_recentValid;
  logic [RPW-1:0]          r_recentPtr;
`endif

  assign w_addr[0]  = pref_addr1_i & BLOCK_MASK;
  assign w_addr[1]  = pref_addr2_i & BLOCK_MASK;
  assign w_addr[2]  = pref_addr3_i & BLOCK_MASK;
  assign w_valid    = {pref_valid3_i, pref_valid2_i, pref_valid1_i};
  assign w_notEmpty = (r_count != '0);
  assign w_deq      = w_notEmpty && req_ready_i;
  assign w_space    = CW'(QUEUE_DEPTH) - r_count + CW'(w_deq);

  assign req_valid_o  = w_notEmpty;
  assign req_addr_o   = w_notEmpty ? r_mem[r_rdPtr] : '0;
  assign count_o      = r_count;
  assign drop_count_o = r_drop;
  assign w_dropSum    = {1'b0, r_drop} + 17'(w_numDrop);

  // An entry is live when its distance from the read pointer is below the occupancy.
  always_comb begin
    for (int i = 0; i < QUEUE_DEPTH; i++) begin
      w_occ[i] = ({1'b0, PW'(i) - r_rdPtr}) < r_count;
    end
  end

  always_comb begin
    logic [1:0] acc;
    logic [1:0] drp;
    logic       dup;
    acc      = '0;
    drp      = '0;
    dup      = 1'b0;
    w_accept = '0;
    for (int k = 0; k < 3; k++) begin
      w_wrIdx[k] = r_wrPtr + PW'(acc);
      dup = 1'b0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        if (w_occ[i] && (r_mem[i] == w_addr[k])) dup = 1'b1;
      end
      for (int j = 0; j < 3; j++) begin
        if ((j < k) && w_valid[j] && (w_addr[j] == w_addr[k])) dup = 1'b1;
      end
`ifdef PF_RECENT_FILTER_EN
      for (int r = 0; r < RECENT_COUNT; r++) begin
        if (r_recentValid[r] && (r_recent[r] == w_addr[k])) dup = 1'b1;
      end
`endif
      // Survivors are taken in slot order, so lack of space always sheds the highest slots.
      if (w_valid[k] && !dup) begin
        if (CW'(acc) < w_space) begin
          w_accept[k] = 1'b1;
          acc = acc + 2'd1;
        end else begin
          drp = drp + 2'd1;
        end
      end
    end
    w_numAcc  = acc;
    w_numDrop = drp;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < QUEUE_DEPTH; i++) r_mem[i] <= '0;
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_count <= '0;
      r_drop  <= '0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (w_accept[k]) r_mem[w_wrIdx[k]] <= w_addr[k];
      end
      r_wrPtr <= r_wrPtr + PW'(w_numAcc);
      if (w_deq) r_rdPtr <= r_rdPtr + PW'(1);
      r_count <= r_count + CW'(w_numAcc) - CW'(w_deq);
      r_drop  <= w_dropSum[16] ? 16'hFFFF : w_dropSum[15:0];
    end
  end

`ifdef PF_RECENT_FILTER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < RECENT_COUNT; r++) r_recent[r] <= '0;
      r_recentValid <= '0;
      r_recentPtr   <= '0;
    end else if (w_deq) begin
      r_recent[r_recentPtr]      <= r_mem[r_rdPtr];
      r_recentValid[r_recentPtr] <= 1'b1;
      r_recentPtr <= (r_recentPtr == RPW'(RECENT_COUNT - 1)) ? '0 : r_recentPtr + RPW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_pf_issue_queue.sv
// Scoreboard bench for pf_issue_queue: a queue-based reference model predicts issues,
// occupancy and drop counts; a negedge monitor checks every handshake and hold stability.
module tb_pf_issue_queue;

  localparam int DEPTH = 8;
  localparam int RC    = 16;
  localparam logic [63:0] MASK = ~64'h3F;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] pref_addr1_i = '0, pref_addr2_i = '0, pref_addr3_i = '0;
  logic        pref_valid1_i = 1'b0, pref_valid2_i = 1'b0, pref_valid3_i = 1'b0;
  logic [63:0] req_addr_o;
  logic        req_valid_o;
  logic        req_ready_i = 1'b0;
  logic [3:0]  count_o;
  logic [15:0] drop_count_o;

  int errors = 0;
  int checks = 0;
  logic [63:0] mq[$];
  logic [63:0] sbq[$];
  logic [63:0] recent[$];
  int expCount = 0;
  int expDrop  = 0;
  logic        prevHold = 1'b0;
  logic [63:0] prevAddr = '0;

  always #5 clk = ~clk;

  pf_issue_queue #(.QUEUE_DEPTH(DEPTH), .RECENT_COUNT(RC), .ADDR_SIZE(64), .LOG2_BLOCK_SIZE(6)) dut (
    .clk(clk), .rst(rst),
    .pref_addr1_i(pref_addr1_i), .pref_valid1_i(pref_valid1_i),
    .pref_addr2_i(pref_addr2_i), .pref_valid2_i(pref_valid2_i),
    .pref_addr3_i(pref_addr3_i), .pref_valid3_i(pref_valid3_i),
    .req_addr_o(req_addr_o), .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
    .count_o(count_o), .drop_count_o(drop_count_o)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of candidates and advance the reference model across the coming edge.
  task automatic applyStimulus(input logic v1, input logic [63:0] a1, input logic v2, input logic [63:0] a2,
                               input logic v3, input logic [63:0] a3, input logic rdy);
    logic [63:0] al[3];
    logic        vv[3];
    logic [63:0] acc[$];
    bit          dup;
    bit          deq;
    int          space;
    @(posedge clk);
    #1;
    checkOutput("count", 64'(count_o), 64'(expCount));
    checkOutput("drop", 64'(drop_count_o), 64'(expDrop));
    checkOutput("valid", 64'(req_valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) checkOutput("head", req_addr_o, mq[0]);
    pref_valid1_i = v1; pref_addr1_i = a1;
    pref_valid2_i = v2; pref_addr2_i = a2;
    pref_valid3_i = v3; pref_addr3_i = a3;
    req_ready_i   = rdy;
    al[0] = a1 & MASK; al[1] = a2 & MASK; al[2] = a3 & MASK;
    vv[0] = v1; vv[1] = v2; vv[2] = v3;
    deq   = rdy && (mq.size() != 0);
    space = DEPTH - mq.size() + (deq ? 1 : 0);
    for (int k = 0; k < 3; k++) begin
      if (vv[k]) begin
        dup = 0;
        foreach (mq[i]) if (mq[i] == al[k]) dup = 1;
        for (int j = 0; j < k; j++) if (vv[j] && al[j] == al[k]) dup = 1;
`ifdef PF_RECENT_FILTER_EN
        foreach (recent[i]) if (recent[i] == al[k]) dup = 1;
`endif
        if (!dup) begin
          if (acc.size() < space) acc.push_back(al[k]);
          else if (expDrop < 65535) expDrop++;
        end
      end
    end
    if (deq) begin
      recent.push_back(mq.pop_front());
      if (recent.size() > RC) void'(recent.pop_front());
    end
    foreach (acc[i]) begin
      mq.push_back(acc[i]);
      sbq.push_back(acc[i]);
    end
    expCount = mq.size();
  endtask

  task automatic idle(input logic rdy);
    applyStimulus(1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, rdy);
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("rstValid", 64'(req_valid_o), 64'h0);
    checkOutput("rstCount", 64'(count_o), 64'h0);
    checkOutput("rstDrop", 64'(drop_count_o), 64'h0);
    checkOutput("rstAddr", req_addr_o, 64'h0);
    mq.delete(); sbq.delete(); recent.delete();
    expCount = 0; expDrop = 0;
    pref_valid1_i = 1'b0; pref_valid2_i = 1'b0; pref_valid3_i = 1'b0; req_ready_i = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: inputs are stable at the falling edge, so a handshake seen here completes at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      if (prevHold) checkOutput("holdStable", req_addr_o, prevAddr);
      if (req_valid_o && req_ready_i) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL issue: got %0h, expected no request", req_addr_o);
        end else begin
          checkOutput("issue", req_addr_o, sbq.pop_front());
        end
      end
      prevHold = req_valid_o && !req_ready_i;
      prevAddr = req_addr_o;
    end else begin
      prevHold = 1'b0;
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstValid", 64'(req_valid_o), 64'h0);
    checkOutput("rstCount", 64'(count_o), 64'h0);
    checkOutput("rstDrop", 64'(drop_count_o), 64'h0);
    checkOutput("rstAddr", req_addr_o, 64'h0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) idle(1'b0);

    applyStimulus(1'b1, 64'h1045, 1'b1, 64'h1085, 1'b1, 64'h10C5, 1'b0);
    idle(1'b0);
    checkOutput("alignHead", req_addr_o, 64'h1040);
    checkOutput("alignCount", 64'(count_o), 64'd3);
    repeat (4) idle(1'b1);

    applyStimulus(1'b1, 64'h2000, 1'b1, 64'h2010, 1'b1, 64'h2000, 1'b0);
    applyStimulus(1'b1, 64'h2000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0);
    idle(1'b0);
    checkOutput("dupCount", 64'(count_o), 64'd1);
    repeat (3) idle(1'b1);

    applyStimulus(1'b1, 64'h8000, 1'b1, 64'h8040, 1'b1, 64'h8080, 1'b0);
    applyStimulus(1'b1, 64'h80C0, 1'b1, 64'h8100, 1'b1, 64'h8140, 1'b0);
    applyStimulus(1'b1, 64'h8180, 1'b1, 64'h81C0, 1'b0, 64'h0, 1'b0);
    applyStimulus(1'b1, 64'h9000, 1'b1, 64'h9040, 1'b1, 64'h9080, 1'b0);
    applyStimulus(1'b1, 64'h9100, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    idle(1'b0);
    checkOutput("ovfCount", 64'(count_o), 64'd8);
    repeat (10) idle(1'b1);

    applyStimulus(1'b1, 64'hA000, 1'b1, 64'hA040, 1'b1, 64'hA080, 1'b0);
    applyStimulus(1'b1, 64'hA0C0, 1'b1, 64'hA100, 1'b0, 64'h0, 1'b0);
    for (int i = 0; i < 12; i++) idle(i[0]);
    repeat (2) idle(1'b1);

    applyStimulus(1'b1, 64'h3000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    repeat (2) idle(1'b1);
    applyStimulus(1'b1, 64'h3000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    repeat (2) idle(1'b1);
    for (int i = 0; i < 16; i++) applyStimulus(1'b1, 64'h5000 + 64'(i) * 64'h40, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    repeat (3) idle(1'b1);
    applyStimulus(1'b1, 64'h3000, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1);
    repeat (3) idle(1'b1);

    applyStimulus(1'b1, 64'h6000, 1'b1, 64'h6040, 1'b1, 64'h6080, 1'b0);
    doReset();
    repeat (2) idle(1'b0);

    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 9) < 6, 64'h4000 + 64'($urandom_range(0, 23)) * 64'h40 + 64'($urandom_range(0, 63)),
                    $urandom_range(0, 9) < 6, 64'h4000 + 64'($urandom_range(0, 23)) * 64'h40 + 64'($urandom_range(0, 63)),
                    $urandom_range(0, 9) < 6, 64'h4000 + 64'($urandom_range(0, 23)) * 64'h40 + 64'($urandom_range(0, 63)),
                    $urandom_range(0, 1) == 1);
    end
    repeat (12) idle(1'b1);
    checkOutput("scoreboardEmpty", 64'(sbq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pf_issue_queue.md
Name: pf_issue_queue

Overview:
- Consumer end of the IP-stride prefetcher's candidate interface.
- Each cycle, accepts up to three prefetch candidates (slots 1..3) and block-aligns them.
- Drops duplicates, buffers survivors in an in-order FIFO, and issues them one per handshake to the L2 request port over valid/ready.
- The upstream interface has no backpressure: candidates the queue cannot take are dropped and counted.

Parameters:
- QUEUE_DEPTH, 8, FIFO entries; power of two, at least 4.
- RECENT_COUNT, 16, entries in the recently-issued filter (used only with the optional feature).
- ADDR_SIZE, 64, address width.
- LOG2_BLOCK_SIZE, 6, cache-block offset bits.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- pref_addr1_i  in  ADDR_SIZE  candidate 1 address.
- pref_valid1_i  in  1  candidate 1 valid.
- pref_addr2_i  in  ADDR_SIZE  candidate 2 address.
- pref_valid2_i  in  1  candidate 2 valid.
- pref_addr3_i  in  ADDR_SIZE  candidate 3 address.
- pref_valid3_i  in  1  candidate 3 valid.
- req_addr_o  out  ADDR_SIZE  head entry address, block-aligned.
- req_valid_o  out  1  queue non-empty.
- req_ready_i  in  1  downstream accepts the request.
- count_o  out  $clog2(QUEUE_DEPTH)+1  current occupancy.
- drop_count_o  out  16  saturating count of candidates lost to a full queue.

Behaviour:
- Reset (rst low, async):
  - Queue emptied; read and write pointers 0.
  - req_valid_o=0, req_addr_o=0, count_o=0, drop_count_o=0.
  - Recent filter invalidated.
- Alignment: candidate low LOG2_BLOCK_SIZE bits are forced to 0 before any compare or store.
- Dequeue:
  - Fires when req_valid_o && req_ready_i.
  - The read pointer advances at the edge.
  - req_addr_o is valid whenever req_valid_o=1 and must hold stable while req_valid_o=1 and req_ready_i=0.
- Duplicate rule: a valid candidate is dropped as a duplicate if its aligned address equals any of:
  - an occupied queue entry, including the head being dequeued this cycle;
  - an earlier valid candidate slot in the same cycle;
  - any valid recent-filter entry (feature on only).
  - Duplicates are not counted in drop_count_o.
- Enqueue order:
  - Surviving candidates enqueue in slot order 1, 2, 3, packed contiguously at the write pointer.
  - Available space = QUEUE_DEPTH - count + (dequeue this cycle ? 1 : 0).
  - Survivors beyond available space are dropped, highest slot first (slot 1 kept preferentially).
  - drop_count_o adds the number dropped, saturating at 16'hFFFF.
- Latency: a candidate presented in cycle N can appear on req_addr_o at cycle N+1 at the earliest; there is no combinational input-to-output path.
- Occupancy: count_o is the registered occupancy after the edge's enqueue and dequeue, range 0..QUEUE_DEPTH.
- Pointer wrap: pointers wrap modulo QUEUE_DEPTH, with full/empty resolved by count.
- Simultaneous dequeue and enqueue on a full queue: up to one candidate is accepted.
- Invalid slots: pref_validN_i=0 makes that slot's address a don't-care.
- Reset mid-operation: all queued and filtered state is discarded immediately; no partial handshake completes.

Optional Feature:
- Macro: PF_RECENT_FILTER_EN.
- Defined:
  - An RECENT_COUNT-entry filter records each address at dequeue.
  - Replacement is round-robin via a wrapping insert pointer; entries carry valid bits cleared by reset.
  - Candidates matching a valid filter entry are dropped as duplicates.
  - An address dequeued at edge E is filtered for candidates from cycle E onward.
- Undefined: no filter storage; duplicates are checked only against queue entries and same-cycle slots.

Test Plan:
- Reset then idle:
  - Stimulus: hold rst low, then release; drive no valid candidates.
  - Response: req_valid_o=0, count_o=0, drop_count_o=0 throughout.
- Three-candidate alignment and order:
  - Stimulus: one cycle with addr1=0x1045, addr2=0x1085, addr3=0x10C5, all valid; req_ready_i=0.
  - Response: next cycle count_o=3, req_addr_o=0x1040.
  - Then req_ready_i=1: issue order 0x1040, 0x1080, 0x10C0.
- Duplicate rejection:
  - Stimulus: addr1=0x2000, addr2=0x2010, addr3=0x2000.
  - Response: one entry, count_o=1, drop_count_o=0.
  - Stimulus: re-present 0x2000 the next cycle.
  - Response: count_o stays 1.
- Overflow:
  - Stimulus: req_ready_i=0; fill with 8 distinct blocks, then present 0x9000, 0x9040, 0x9080.
  - Response: count_o=8, drop_count_o=3.
  - Stimulus: same cycle with req_ready_i=1 and one candidate.
  - Response: that candidate is accepted, count_o=8.
- Backpressure stability:
  - Stimulus: req_ready_i toggles 0/1 every cycle while 5 distinct entries drain.
  - Response: req_addr_o is constant during ready=0 cycles; the 5 addresses issue in FIFO order.
- Filter (feature on):
  - Stimulus: issue 0x3000, then present 0x3000 again after it dequeues.
  - Response: candidate rejected.
  - Stimulus: after 16 further distinct issues, present 0x3000 again.
  - Response: accepted.
